subleq_ctrl: RTL
================

// Module: subleq_ctrl
// PURPOSE
//   Sequencer for the SUBLEQ machine: fetches the three operand addresses A, B, C.
//   Executes mem[B] <= mem[B] - mem[A], then branches to C if the result is <= 0.
//   Sits directly upstream of the PC register and drives its mod/inp inputs.
//   Also owns the single shared memory port through a rd/wr/rdy handshake.
// PARAMETERS
//   AW  8  address width; equals the PC register width
//   DW  8  data width; two's-complement operands
// PORTS
//   clk        in   1   system clock, rising edge
//   res        in   1   asynchronous reset, active-high; the PC register reset is driven from ~res at top level
//   run        in   1   1 = start a new instruction from S_FA; 0 = idle in S_FA
//   pc_val     in   AW  current PC, from PC register out
//   pc_mod     out  2   PC command: 0 = hold, 1 = increment, 2 = load pc_tgt
//   pc_tgt     out  AW  branch target, to PC register inp
//   mem_addr   out  AW  memory address
//   mem_rd     out  1   read request
//   mem_wr     out  1   write request
//   mem_wdata  out  DW  write data
//   mem_rdata  in   DW  read data, valid when mem_rdy=1 during a read
//   mem_rdy    in   1   access complete; may be high in the request cycle (zero-wait)
//   instr_done out  1   one-cycle pulse in S_BR
//   halted     out  1   in S_HALT (only with SUBLEQ_HALT_EN)
// BEHAVIOUR
//   Reset: state=S_FA; a/b/c/opa/diff regs=0; all outputs 0.
//   Reset mid-access drops mem_rd/mem_wr in the same instant, with no completion.
//   FSM: S_FA -> S_FB -> S_FC -> S_LA -> S_LB -> S_WR -> S_BR -> S_FA.
//   S_FA/S_FB/S_FC:
//     - mem_rd=1, mem_addr=pc_val.
//     - On mem_rdy: capture a/b/c <= mem_rdata, pc_mod=1 for that cycle only, then advance.
//     - S_FA with run=0: no request, pc_mod=0, stay.
//   S_LA: mem_rd=1, mem_addr=a; on mem_rdy, opa <= mem_rdata.
//   S_LB: mem_rd=1, mem_addr=b; on mem_rdy, diff <= mem_rdata - opa.
//     - Subtraction is DW-bit modulo 2^DW; overflow ignored, no saturation.
//   S_WR: mem_wr=1, mem_addr=b, mem_wdata=diff; advance on mem_rdy.
//   S_BR:
//     - instr_done=1, pc_tgt=c.
//     - pc_mod=2 if diff[DW-1]==1 or diff==0, else pc_mod=0.
//     - PC already points past C, so the not-taken case needs no increment.
//   Handshake:
//     - Request and mem_addr/mem_wdata stay stable until the mem_rdy cycle.
//     - mem_rd and mem_wr are never both high.
//     - In the cycle after mem_rdy the request belongs to the next state.
//   pc_mod is 0 in every cycle not listed above; pc_tgt is c in all states.
//   Latency: zero-wait memory gives 7 cycles per instruction; each wait cycle adds 1.
//   Boundaries:
//     - PC wrap 8'hFF -> 8'h00 is the PC register's concern; fetch continues at wrapped address.
//     - A==B is legal: result is 0 and the branch is taken.
//     - A self-modifying write to the next instruction's operands is seen by the next fetch.
// CONFIGURATION
//   SUBLEQ_HALT_EN defined:
//     - In S_BR with a taken branch and c == all-ones: pc_mod=2, then go to S_HALT.
//     - S_HALT: halted=1, no memory requests, pc_mod=0; left only by res.
//   Not defined: no S_HALT; halted tied 0; a branch to all-ones is an ordinary jump.
// TESTING
//   1. Reset: res pulse mid-S_LB with mem_rd=1 -> mem_rd drops immediately; state S_FA; all outputs 0.
//   2. Not-taken: mem[0..2]={10,11,3}, mem[10]=2, mem[11]=5, zero-wait memory
//      -> mem[11]=3; pc_mod 1,1,1 then 0; PC=3; instr_done at cycle 7.
//   3. Taken, zero: mem[0..2]={10,10,40}, mem[10]=7 -> mem[10]=0; pc_mod=2 with pc_tgt=40; next fetch at 40.
//   4. Wrap: mem[A]=1, mem[B]=8'h80 -> diff=8'h7F (positive), not taken;
//      mem[A]=8'h01, mem[B]=8'h00 -> diff=8'hFF, taken.
//   5. Wait states: mem_rdy delayed 3 cycles on every access
//      -> addr/rd/wr stable throughout; instruction takes 25 cycles; single pc_mod=1 per fetch.
//   6. HALT_EN: taken branch with c=8'hFF -> halted=1 from the next cycle; no further mem_rd over 20 cycles.
//      Without the macro the same program fetches from address 8'hFF.

Source files
------------

// File: rtl/subleq_ctrl.sv
// subleq_ctrl: SUBLEQ instruction sequencer that drives the PC register and owns the shared memory port.
// Optional feature: define SUBLEQ_HALT_EN to park in S_HALT after a taken branch to the all-ones address.
module subleq_ctrl #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          res,
  input  logic          run,
  input  logic [AW-1:0] pc_val,
  output logic [1:0]    pc_mod,
  output logic [AW-1:0] pc_tgt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy,
  output logic          instr_done,
  output logic          halted
);

  localparam logic [1:0] PC_HOLD = 2'd0;
  localparam logic [1:0] PC_INC  = 2'd1;
  localparam logic [1:0] PC_LOAD = 2'd2;

  typedef enum logic [2:0] {
    S_FA = 3'd0,
    S_FB = 3'd1,
    S_FC = 3'd2,
    S_LA = 3'd3,
    S_LB = 3'd4,
    S_WR = 3'd5,
    S_BR = 3'd6
`ifdef SUBLEQ_HALT_EN
    ,
    S_HALT = 3'd7
`endif
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] a;
  logic [AW-1:0] b;
  logic [AW-1:0] c;
  logic [DW-1:0] opa;
  logic [DW-1:0] diff;
  logic          taken;
  logic          rd_done;

  // Branch when the stored result is negative or zero
  assign taken   = diff[DW-1] | (diff == '0);
  assign rd_done = mem_rd & mem_rdy;
  assign pc_tgt  = c;

  // State register and operand/result capture on completed reads
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= S_FA;
      a     <= '0;
      b     <= '0;
      c     <= '0;
      opa   <= '0;
      diff  <= '0;
    end else begin
      state <= state_nx;
      if (rd_done) begin
        case (state)
          S_FA:    a    <= AW'(mem_rdata);
          S_FB:    b    <= AW'(mem_rdata);
          S_FC:    c    <= AW'(mem_rdata);
          S_LA:    opa  <= mem_rdata;
          S_LB:    diff <= DW'(mem_rdata - opa);
          default: ;
        endcase
      end
    end
  end

  // Next state and memory/PC commands; reset forces every request low at once
  always_comb begin
    state_nx   = state;
    pc_mod     = PC_HOLD;
    mem_addr   = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_wdata  = '0;
    instr_done = 1'b0;
    halted     = 1'b0;
    if (!res) begin
      case (state)
        S_FA: begin
          if (run) begin
            mem_rd   = 1'b1;
            mem_addr = pc_val;
            if (mem_rdy) begin
              pc_mod   = PC_INC;
              state_nx = S_FB;
            end
          end
        end
        S_FB: begin
          mem_rd   = 1'b1;
          mem_addr = pc_val;
          if (mem_rdy) begin
            pc_mod   = PC_INC;
            state_nx = S_FC;
          end
        end
        S_FC: begin
          mem_rd   = 1'b1;
          mem_addr = pc_val;
          if (mem_rdy) begin
            pc_mod   = PC_INC;
            state_nx = S_LA;
          end
        end
        S_LA: begin
          mem_rd   = 1'b1;
          mem_addr = a;
          if (mem_rdy) state_nx = S_LB;
        end
        S_LB: begin
          mem_rd   = 1'b1;
          mem_addr = b;
          if (mem_rdy) state_nx = S_WR;
        end
        S_WR: begin
          mem_wr    = 1'b1;
          mem_addr  = b;
          mem_wdata = diff;
          if (mem_rdy) state_nx = S_BR;
        end
        S_BR: begin
          // PC already sits past C, so not-taken simply holds
          instr_done = 1'b1;
          state_nx   = S_FA;
          if (taken) begin
            pc_mod = PC_LOAD;
`ifdef SUBLEQ_HALT_EN
            if (&c) state_nx = S_HALT;
`endif
          end
        end
`ifdef SUBLEQ_HALT_EN
        S_HALT: begin
          halted = 1'b1;
        end
`endif
        default: state_nx = S_FA;
      endcase
    end
  end

endmodule
